// File: rtl/vga_scan_timer.sv
// VGA raster timing (default 640x480@60) with a pixel-rate enable and a per-frame scroll offset.
// Optional macro VGA_OUT_REG_EN registers x/y/video_on/hsync/vsync for one extra clk of latency.
module vga_scan_timer #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] scroll_speed,
    input  logic       pause,
    output logic       pixel_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick,
    output logic [9:0] frame_offset
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] r_div;
    logic [9:0] r_h_count;
    logic [9:0] r_v_count;
    logic [9:0] r_frame_offset;

    logic w_h_last;
    logic w_v_last;
    logic w_frame_tick;
    logic w_video_on;
    logic w_hsync;
    logic w_vsync;

    // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so the enable is permanently high.
    assign pixel_tick   = (r_div == DIV_LAST);
    assign w_h_last     = (r_h_count == H_LAST);
    assign w_v_last     = (r_v_count == V_LAST);
    assign w_frame_tick = pixel_tick && w_h_last && w_v_last;

    // NOTE: state registers use non-blocking assignments so every counter sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
        end else if (pixel_tick) begin
            if (w_h_last) begin
                r_h_count <= '0;
                r_v_count <= w_v_last ? 10'd0 : r_v_count + 10'd1;
            end else begin
                r_h_count <= r_h_count + 10'd1;
            end
        end
    end

    // scroll_speed is only looked at on the frame boundary; the add wraps naturally at 1024.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_offset <= '0;
        end else if (w_frame_tick && !pause) begin
            r_frame_offset <= r_frame_offset + {6'd0, scroll_speed};
        end
    end

    assign w_video_on = (r_h_count < H_VIS) && (r_v_count < V_VIS);
    assign w_hsync    = !((r_h_count >= HS_START) && (r_h_count < HS_END));
    assign w_vsync    = !((r_v_count >= VS_START) && (r_v_count < VS_END));

    assign frame_tick   = w_frame_tick;
    assign frame_offset = r_frame_offset;

`ifdef VGA_OUT_REG_EN
    logic [9:0] r_x_out;
    logic [9:0] r_y_out;
    logic       r_video_on_out;
    logic       r_hsync_out;
    logic       r_vsync_out;

    // Sync outputs idle high out of reset; video stays blanked until the first registered decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_out        <= '0;
            r_y_out        <= '0;
            r_video_on_out <= 1'b0;
            r_hsync_out    <= 1'b1;
            r_vsync_out    <= 1'b1;
        end else begin
            r_x_out        <= r_h_count;
            r_y_out        <= r_v_count;
            r_video_on_out <= w_video_on;
            r_hsync_out    <= w_hsync;
            r_vsync_out    <= w_vsync;
        end
    end

    assign x        = r_x_out;
    assign y        = r_y_out;
    assign video_on = r_video_on_out;
    assign hsync    = r_hsync_out;
    assign vsync    = r_vsync_out;
`else
    assign x        = r_h_count;
    assign y        = r_v_count;
    assign video_on = w_video_on;
    assign hsync    = w_hsync;
    assign vsync    = w_vsync;
`endif

endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: full-size line timing, a CLK_DIV=1 tall frame, and a tiny frame for scroll tests.
module tb_vga_scan_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: default 640x480, CLK_DIV=4
    logic       rst_a, pause_a;
    logic [3:0] spd_a;
    logic       a_pixel_tick, a_video_on, a_hsync, a_vsync, a_frame_tick;
    logic [9:0] a_x, a_y, a_frame_offset;

    // Instance b: CLK_DIV=1, 16-pixel lines, full 525-line frame
    logic       rst_b, pause_b;
    logic [3:0] spd_b;
    logic       b_pixel_tick, b_video_on, b_hsync, b_vsync, b_frame_tick;
    logic [9:0] b_x, b_y, b_frame_offset;

    // Instance c: CLK_DIV=1, 8x6 frame (48 clks) for scroll accumulation
    logic       rst_c, pause_c;
    logic [3:0] spd_c;
    logic       c_pixel_tick, c_video_on, c_hsync, c_vsync, c_frame_tick;
    logic [9:0] c_x, c_y, c_frame_offset;

    vga_scan_timer dut_a (
        .clk(clk), .reset(rst_a), .scroll_speed(spd_a), .pause(pause_a),
        .pixel_tick(a_pixel_tick), .x(a_x), .y(a_y), .video_on(a_video_on),
        .hsync(a_hsync), .vsync(a_vsync), .frame_tick(a_frame_tick),
        .frame_offset(a_frame_offset)
    );

    vga_scan_timer #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3)
    ) dut_b (
        .clk(clk), .reset(rst_b), .scroll_speed(spd_b), .pause(pause_b),
        .pixel_tick(b_pixel_tick), .x(b_x), .y(b_y), .video_on(b_video_on),
        .hsync(b_hsync), .vsync(b_vsync), .frame_tick(b_frame_tick),
        .frame_offset(b_frame_offset)
    );

    vga_scan_timer #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_c (
        .clk(clk), .reset(rst_c), .scroll_speed(spd_c), .pause(pause_c),
        .pixel_tick(c_pixel_tick), .x(c_x), .y(c_y), .video_on(c_video_on),
        .hsync(c_hsync), .vsync(c_vsync), .frame_tick(c_frame_tick),
        .frame_offset(c_frame_offset)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // k = posedges since reset release; expected x = k/4, pixel_tick = (k%4 == 3)
    typedef struct {
        int k;
        int x;
        int y;
        bit von;
        bit hs;
        bit vs;
        bit pt;
    } line_vec_t;

    line_vec_t vecs[11];

    // Advance to the negedge following the next frame_tick of instance c (offset already updated).
    task automatic frames_c(input int n);
        for (int f = 0; f < n; f++) begin
            int waited;
            waited = 0;
            @(negedge clk);
            while (!c_frame_tick && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            check("c_frame_tick_seen", c_frame_tick, 1);
            @(negedge clk);
            check("c_frame_tick_width", c_frame_tick, 0);
        end
    endtask

    task automatic reset_c();
        rst_c = 1'b1;
        repeat (3) @(negedge clk);
        rst_c = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int falls, ticks, low_ticks, fall_x;
        int tick_at_fall[2];
        int k_at_fall[2];
        logic prev_hs;
        int vs_low, vs_fall_y, von_bad, ft_n, ft_wide, pt_bad;
        int ft_k[2];
        logic prev_vs, prev_ft;
        int n;

        vecs[0]  = '{k: 0,    x: 0,   y: 0, von: 1, hs: 1, vs: 1, pt: 0};
        vecs[1]  = '{k: 3,    x: 0,   y: 0, von: 1, hs: 1, vs: 1, pt: 1};
        vecs[2]  = '{k: 4,    x: 1,   y: 0, von: 1, hs: 1, vs: 1, pt: 0};
        vecs[3]  = '{k: 2559, x: 639, y: 0, von: 1, hs: 1, vs: 1, pt: 1};
        vecs[4]  = '{k: 2560, x: 640, y: 0, von: 0, hs: 1, vs: 1, pt: 0};
        vecs[5]  = '{k: 2623, x: 655, y: 0, von: 0, hs: 1, vs: 1, pt: 1};
        vecs[6]  = '{k: 2624, x: 656, y: 0, von: 0, hs: 0, vs: 1, pt: 0};
        vecs[7]  = '{k: 3007, x: 751, y: 0, von: 0, hs: 0, vs: 1, pt: 1};
        vecs[8]  = '{k: 3008, x: 752, y: 0, von: 0, hs: 1, vs: 1, pt: 0};
        vecs[9]  = '{k: 3199, x: 799, y: 0, von: 0, hs: 1, vs: 1, pt: 1};
        vecs[10] = '{k: 3200, x: 0,   y: 1, von: 1, hs: 1, vs: 1, pt: 0};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        spd_a = '0; spd_b = '0; spd_c = '0;
        pause_a = 1'b0; pause_b = 1'b0; pause_c = 1'b0;

        // Three clocks of reset, then release on a negedge
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        check("a_rst_frame_offset", a_frame_offset, 0);
        check("a_rst_frame_tick", a_frame_tick, 0);

        k = 0;
        foreach (vecs[i]) begin
            while (k < vecs[i].k) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("a_vec%0d_x", i), a_x, vecs[i].x);
            check($sformatf("a_vec%0d_y", i), a_y, vecs[i].y);
            check($sformatf("a_vec%0d_video_on", i), a_video_on, vecs[i].von);
            check($sformatf("a_vec%0d_hsync", i), a_hsync, vecs[i].hs);
            check($sformatf("a_vec%0d_vsync", i), a_vsync, vecs[i].vs);
            check($sformatf("a_vec%0d_pixel_tick", i), a_pixel_tick, vecs[i].pt);
        end

        // hsync pulse width and line period
        falls = 0; ticks = 0; low_ticks = 0; fall_x = -1;
        tick_at_fall[0] = 0; tick_at_fall[1] = 0;
        k_at_fall[0] = 0; k_at_fall[1] = 0;
        prev_hs = a_hsync;
        for (int i = 0; i < 7000 && falls < 2; i++) begin
            @(negedge clk);
            k++;
            if (a_pixel_tick) ticks++;
            if (prev_hs && !a_hsync) begin
                if (falls == 0) fall_x = a_x;
                tick_at_fall[falls] = ticks;
                k_at_fall[falls] = k;
                falls++;
            end
            if (falls == 1 && !a_hsync && a_pixel_tick) low_ticks++;
            prev_hs = a_hsync;
        end
        check("a_hsync_falls", falls, 2);
        check("a_hsync_fall_x", fall_x, 656);
        check("a_hsync_low_ticks", low_ticks, 96);
        check("a_hsync_period_ticks", tick_at_fall[1] - tick_at_fall[0], 800);
        check("a_hsync_period_clks", k_at_fall[1] - k_at_fall[0], 3200);

        // Mid-line reset on instance a
        for (int i = 0; i < 4000 && a_x != 10'd700; i++) @(negedge clk);
        check("a_pre_reset_x", a_x, 700);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("a_midrst_x", a_x, 0);
        check("a_midrst_y", a_y, 0);
        check("a_midrst_hsync", a_hsync, 1);
        check("a_midrst_video_on", a_video_on, 1);
        check("a_midrst_pixel_tick", a_pixel_tick, 0);
        check("a_midrst_frame_offset", a_frame_offset, 0);
        ticks = 0;
        for (int i = 0; i < 4000 && a_y == 10'd0; i++) begin
            @(negedge clk);
            if (a_y == 10'd0 && a_pixel_tick) ticks++;
        end
        check("a_first_line_ticks", ticks, 800);
        check("a_second_line_y", a_y, 1);
        check("a_second_line_x", a_x, 0);

        // Instance b: CLK_DIV=1 pixel enable, vertical timing, frame_tick spacing
        rst_b = 1'b0;
        check("b_rst_pixel_tick", b_pixel_tick, 1);
        check("b_rst_y", b_y, 0);
        vs_low = 0; vs_fall_y = -1; von_bad = 0; ft_n = 0; ft_wide = 0; pt_bad = 0;
        ft_k[0] = -1; ft_k[1] = -1;
        prev_vs = 1'b1; prev_ft = 1'b0;
        for (int kb = 0; kb < 16810; kb++) begin
            if (!b_vsync) begin
                vs_low++;
                if (prev_vs && vs_fall_y < 0) vs_fall_y = int'(b_y);
            end
            if (b_video_on && b_y >= 10'd480) von_bad++;
            if (b_frame_tick) begin
                if (ft_n < 2) ft_k[ft_n] = kb;
                ft_n++;
                if (prev_ft) ft_wide++;
            end
            if (!b_pixel_tick) pt_bad++;
            prev_vs = b_vsync;
            prev_ft = b_frame_tick;
            @(negedge clk);
        end
        check("b_vsync_fall_y", vs_fall_y, 490);
        check("b_vsync_low_clks", vs_low, 64);
        check("b_video_on_blank_rows", von_bad, 0);
        check("b_frame_tick_count", ft_n, 2);
        check("b_frame_tick_first", ft_k[0], 8399);
        check("b_frame_tick_period", ft_k[1] - ft_k[0], 8400);
        check("b_frame_tick_wide", ft_wide, 0);
        check("b_pixel_tick_low", pt_bad, 0);

        // Instance c: scroll accumulation
        rst_c = 1'b0;
        check("c_rst_frame_offset", c_frame_offset, 0);
        spd_c = 4'd5;
        frames_c(3);
        check("c_speed5_3frames", c_frame_offset, 15);

        reset_c();
        check("c_rst2_frame_offset", c_frame_offset, 0);
        spd_c = 4'd15;
        frames_c(68);
        check("c_speed15_68frames", c_frame_offset, 1020);
        frames_c(1);
        check("c_speed15_69frames_wrap", c_frame_offset, 11);

        pause_c = 1'b1;
        frames_c(2);
        check("c_pause_hold", c_frame_offset, 11);
        pause_c = 1'b0;

        spd_c = 4'd0;
        frames_c(1);
        check("c_speed0_hold", c_frame_offset, 11);

        spd_c = 4'd2;
        repeat (20) @(negedge clk);
        check("c_midframe_no_effect", c_frame_offset, 11);
        spd_c = 4'd9;
        frames_c(1);
        check("c_speed_at_tick_used", c_frame_offset, 20);

        spd_c = 4'd4;
        repeat (20) @(negedge clk);
        spd_c = 4'd0;
        frames_c(1);
        check("c_speed_dropped_before_tick", c_frame_offset, 20);

        spd_c = 4'd1;
        pause_c = 1'b1;
        repeat (20) @(negedge clk);
        pause_c = 1'b0;
        frames_c(1);
        check("c_pause_released_before_tick", c_frame_offset, 21);

        // Mid-frame reset with a non-zero offset
        reset_c();
        spd_c = 4'd8;
        frames_c(5);
        check("c_speed8_5frames", c_frame_offset, 40);
        spd_c = 4'd0;
        for (int i = 0; i < 100 && !(c_x == 10'd5 && c_y == 10'd3); i++) @(negedge clk);
        check("c_pre_reset_x", c_x, 5);
        check("c_pre_reset_y", c_y, 3);
        check("c_pre_reset_hsync", c_hsync, 0);
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        check("c_midrst_x", c_x, 0);
        check("c_midrst_y", c_y, 0);
        check("c_midrst_frame_offset", c_frame_offset, 0);
        check("c_midrst_hsync", c_hsync, 1);
        check("c_midrst_vsync", c_vsync, 1);
        check("c_midrst_frame_tick", c_frame_tick, 0);
        n = 0;
        while (!c_frame_tick && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("c_restart_frame_len", n, 47);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
